// File: rtl/mem_stage_ctrl_if.sv
// Signal bundle between the MEM-stage controller and its environment:
// EX/MEM inputs, data-memory req/ack bus, stall and MEM/WB writeback outputs.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              ex_valid;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_regwrite;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_aluresult;
    logic [DATA_W-1:0] ex_wdata;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    logic              stall;
    logic              wb_valid;
    logic              wb_regwrite;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mem_err;

    // Controller side
    modport master (
        input  ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_rd,
        input  ex_aluresult, ex_wdata, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output stall, wb_valid, wb_regwrite, wb_rd, wb_data, mem_err
    );

    // Pipeline and memory side
    modport slave (
        output ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_rd,
        output ex_aluresult, ex_wdata, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  stall, wb_valid, wb_regwrite, wb_rd, wb_data, mem_err
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM/WB boundary controller: runs one variable-latency data-memory access per
// instruction, stalls upstream meanwhile, and loads the MEM/WB register.
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_stage_ctrl_if.master bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q;
    logic              memop, aligned, last_wait, in_wait;
    logic              alu_pass, start, misalign, done, abort, stall_c;

    logic [DATA_W-1:0] addr_p1, wdata_p1;
    logic              we_p1, rd_en_p1, regw_p1;
    logic [REG_W-1:0]  rd_p1;

    logic              wb_valid_q, wb_regwrite_q, mem_err_q;
    logic [REG_W-1:0]  wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;

    assign memop     = bus.ex_memread | bus.ex_memwrite;
    assign aligned   = (bus.ex_aluresult[1:0] == 2'b00);
    assign last_wait = (cnt_q == 8'(TIMEOUT - 1));
    assign in_wait   = (state_q == S_WAIT);
    assign alu_pass  = (state_q == S_IDLE) && bus.ex_valid && !memop;

    always_comb begin
        state_d  = state_q;
        stall_c  = 1'b0;
        start    = 1'b0;
        misalign = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid && memop) begin
                    if (aligned) begin
                        stall_c = 1'b1;
                        start   = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.dmem_ack) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (last_wait) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start)
                cnt_q <= '0;
            else if (in_wait && !bus.dmem_ack && !last_wait)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    // p1: access descriptor latched on IDLE->WAIT, held while the request is up
    always_ff @(posedge clk) begin
        if (start) begin
            addr_p1  <= bus.ex_aluresult;
            wdata_p1 <= bus.ex_wdata;
            we_p1    <= bus.ex_memwrite;
            rd_en_p1 <= bus.ex_memread & ~bus.ex_memwrite;
            regw_p1  <= bus.ex_regwrite;
            rd_p1    <= bus.ex_rd;
        end
    end

    // p2: MEM/WB register; bubbles clear valid/regwrite but keep rd/data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            wb_valid_q    <= alu_pass | done;
            wb_regwrite_q <= (alu_pass & bus.ex_regwrite) | (done & regw_p1);
            mem_err_q     <= misalign | abort;
            if (alu_pass) begin
                wb_rd_q   <= bus.ex_rd;
                wb_data_q <= bus.ex_aluresult;
            end else if (done) begin
                wb_rd_q   <= rd_p1;
                wb_data_q <= rd_en_p1 ? bus.dmem_rdata : addr_p1;
            end
        end
    end

    assign bus.dmem_req    = in_wait;
    assign bus.dmem_we     = in_wait & we_p1;
    assign bus.dmem_addr   = in_wait ? addr_p1 : '0;
    assign bus.dmem_wdata  = in_wait ? wdata_p1 : '0;
    assign bus.stall       = stall_c & rst_n;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_regwrite = wb_regwrite_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.mem_err     = mem_err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected writebacks are queued as each
// instruction is issued and checked when wb_valid appears.
module tb_mem_stage_ctrl;
    typedef struct packed {
        logic        regw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    wb_t  exp_q[$];
    logic [4:0]  last_rd;
    logic [31:0] last_data;

    mem_stage_ctrl_if #(.DATA_W(32), .REG_W(5)) bus ();

    mem_stage_ctrl #(.DATA_W(32), .REG_W(5), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Writeback monitor: every retirement must match the oldest queued entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wb_valid === 1'b1) begin
            wb_t got, e;
            got = '{regw: bus.wb_regwrite, rd: bus.wb_rd, data: bus.wb_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got regw=%0b rd=%0d data=%h, expected no writeback",
                         got.regw, got.rd, got.data);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL wb_data: got regw=%0b rd=%0d data=%h, expected regw=%0b rd=%0d data=%h",
                             got.regw, got.rd, got.data, e.regw, e.rd, e.data);
                end
            end
        end
    end

    task automatic push_wb(input logic regw, input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{regw: regw, rd: rd, data: data});
        last_rd   = rd;
        last_data = data;
    endtask

    task automatic idle_inputs();
        bus.ex_valid     = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_memwrite  = 1'b0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_aluresult = '0;
        bus.ex_wdata     = '0;
        bus.dmem_ack     = 1'b0;
        bus.dmem_rdata   = '0;
    endtask

    // Issue one instruction, hold it while stalled, ack on WAIT cycle ack_at
    // (0 = never). Returns at posedge+1 after the instruction leaves, ex_valid low.
    task automatic run_op(input logic rd_en, input logic wr_en, input logic regw,
                          input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at,
                          input logic [31:0] rdata,
                          output int req_cnt, output int stall_cnt,
                          output int err_early, output int bus_bad);
        bit finished = 0;
        bus.ex_valid     = 1'b1;
        bus.ex_memread   = rd_en;
        bus.ex_memwrite  = wr_en;
        bus.ex_regwrite  = regw;
        bus.ex_rd        = rd;
        bus.ex_aluresult = addr;
        bus.ex_wdata     = wdata;
        req_cnt = 0; stall_cnt = 0; err_early = 0; bus_bad = 0;
        for (int c = 0; c < 40 && !finished; c++) begin
            bus.dmem_ack   = (ack_at > 0 && c == ack_at);
            bus.dmem_rdata = (ack_at > 0 && c == ack_at) ? rdata : 32'hBAD0_0000;
            @(negedge clk);
            if (bus.dmem_req === 1'b1) begin
                req_cnt++;
                if (bus.dmem_addr !== addr || bus.dmem_we !== wr_en ||
                    (wr_en && bus.dmem_wdata !== wdata))
                    bus_bad++;
            end
            if (bus.stall === 1'b1) stall_cnt++;
            if (bus.mem_err !== 1'b0) err_early++;
            finished = (bus.stall !== 1'b1);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!finished) begin
            n_bad++;
            $display("FAIL op_timeout: stall still high after 40 cycles, expected release");
        end
        bus.ex_valid = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    task automatic check_after(input string name, input int req_cnt, input int req_exp,
                               input int stall_cnt, input int stall_exp,
                               input int err_early, input int bus_bad, input logic err_exp);
        // sampled on the cycle after the instruction leaves
        @(negedge clk);
        n_cmp++;
        if (req_cnt != req_exp) begin
            n_bad++; $display("FAIL %s_req_cycles: got %0d, expected %0d", name, req_cnt, req_exp);
        end
        n_cmp++;
        if (stall_cnt != stall_exp) begin
            n_bad++; $display("FAIL %s_stall_cycles: got %0d, expected %0d", name, stall_cnt, stall_exp);
        end
        n_cmp++;
        if (err_early != 0 || bus_bad != 0) begin
            n_bad++; $display("FAIL %s_bus: got err_early=%0d bus_bad=%0d, expected 0/0", name, err_early, bus_bad);
        end
        n_cmp++;
        if (bus.mem_err !== err_exp || bus.dmem_req !== 1'b0) begin
            n_bad++; $display("FAIL %s_post: got mem_err=%b req=%b, expected %b/0", name, bus.mem_err, bus.dmem_req, err_exp);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL %s_missing_wb: got %0d pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.stall,
             bus.wb_valid, bus.wb_regwrite, bus.wb_rd, bus.wb_data, bus.mem_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b wbv=%b rd=%0d data=%h err=%b stall=%b, expected all 0",
                     bus.dmem_req, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.mem_err, bus.stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        int r, s, e, b;
        push_wb(1'b1, 5'd3, 32'h0000_00A5);
        run_op(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_00A5, 32'h0, 0, 32'h0, r, s, e, b);
        check_after("alu", r, 0, s, 0, e, b, 1'b0);
    endtask

    task automatic test_load();
        int r, s, e, b;
        push_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        run_op(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, r, s, e, b);
        check_after("load", r, 3, s, 3, e, b, 1'b0);
    endtask

    task automatic test_store();
        int r, s, e, b;
        push_wb(1'b0, 5'd7, 32'h0000_0200);
        run_op(1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_0200, 32'h1234_5678, 1, 32'h0, r, s, e, b);
        check_after("store", r, 1, s, 1, e, b, 1'b0);
    endtask

    task automatic test_timeout();
        int r, s, e, b;
        run_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0300, 32'h0, 0, 32'h0, r, s, e, b);
        check_after("timeout", r, 15, s, 15, e, b, 1'b1);
        n_cmp++;
        if (bus.mem_err !== 1'b0 || bus.wb_rd !== last_rd || bus.wb_data !== last_data) begin
            n_bad++;
            $display("FAIL timeout_hold: got err=%b rd=%0d data=%h, expected 0 rd=%0d data=%h",
                     bus.mem_err, bus.wb_rd, bus.wb_data, last_rd, last_data);
        end
    endtask

    task automatic test_misaligned();
        int r, s, e, b;
        run_op(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0102, 32'h0, 0, 32'h0, r, s, e, b);
        check_after("misaligned", r, 0, s, 0, e, b, 1'b1);
    endtask

    task automatic test_both_rw();
        int r, s, e, b;
        push_wb(1'b0, 5'd2, 32'h0000_0440);
        run_op(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0440, 32'hCAFE_F00D, 2, 32'h5555_5555, r, s, e, b);
        check_after("both_rw", r, 2, s, 2, e, b, 1'b0);
    endtask

    task automatic test_back_to_back();
        int r, s, e, b;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = {20'h0, $urandom_range(1, 255), 4'h0};
            d = $urandom;
            if (i % 2 == 0) begin
                push_wb(1'b1, 5'(i + 12), a);
                run_op(1'b0, 1'b0, 1'b1, 5'(i + 12), a, 32'h0, 0, 32'h0, r, s, e, b);
            end else begin
                push_wb(1'b1, 5'(i + 12), d);
                run_op(1'b1, 1'b0, 1'b1, 5'(i + 12), a, 32'h0, 1, d, r, s, e, b);
            end
        end
        check_after("b2b", r, 1, s, 1, e, b, 1'b0);
    endtask

    task automatic test_idle_ack();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFF_0000;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0 || bus.mem_err !== 1'b0 || bus.wb_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_ack: got req=%b stall=%b err=%b wbv=%b, expected 0",
                         bus.dmem_req, bus.stall, bus.mem_err, bus.wb_valid);
            end
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        bus.ex_valid     = 1'b1;
        bus.ex_memread   = 1'b1;
        bus.ex_memwrite  = 1'b0;
        bus.ex_regwrite  = 1'b1;
        bus.ex_rd        = 5'd20;
        bus.ex_aluresult = 32'h0000_0400;
        @(posedge clk); #1;          // WAIT cycle 1
        @(posedge clk); #1;          // WAIT cycle 2
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.dmem_req !== 1'b1) begin
            n_bad++; $display("FAIL rst_wait_req_before: got %b, expected 1", bus.dmem_req);
        end
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.ex_valid = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_req, bus.stall, bus.wb_valid, bus.wb_regwrite, bus.wb_rd, bus.wb_data, bus.mem_err} !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_outputs: got req=%b stall=%b wbv=%b rd=%0d data=%h err=%b, expected all 0",
                     bus.dmem_req, bus.stall, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.mem_err);
        end
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dmem_req !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_late_ack: got wbv=%b req=%b, expected 0/0", bus.wb_valid, bus.dmem_req);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_misaligned();
        test_both_rw();
        test_back_to_back();
        test_idle_ack();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Controller for the memory/writeback boundary of the 5-stage pipeline. It takes the instruction leaving EX/MEM and sequences one data-memory access over a variable-latency req/ack interface. It stalls the upstream pipeline while that access is outstanding. It then loads the MEM/WB writeback register, selecting either ALU result or memory read-out, or inserts a bubble on error.

Parameters:
DATA_W, 32, data and address width
REG_W, 5, register-specifier width
TIMEOUT, 15, max WAIT cycles without ack before abort (legal range 1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX/MEM holds a valid instruction
ex_memread  in  1  instruction is a load
ex_memwrite  in  1  instruction is a store
ex_regwrite  in  1  instruction writes the register file
ex_rd  in  REG_W  destination register
ex_aluresult  in  DATA_W  ALU result / effective address
ex_wdata  in  DATA_W  store data
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  DATA_W  word-aligned address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
dmem_rdata  in  DATA_W  load data
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational)
wb_valid  out  1  MEM/WB holds a retired instruction
wb_regwrite  out  1  register-file write enable
wb_rd  out  REG_W  writeback register
wb_data  out  DATA_W  writeback data
mem_err  out  1  one-cycle error pulse (misaligned or timeout)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: state IDLE, timeout counter 0. All outputs 0: dmem_*, wb_*, mem_err. stall is 0.
- Reset has priority in every state. If asserted in WAIT, the request drops at the next edge, and any later ack is ignored.
- memop = ex_memread | ex_memwrite.
- If both memread and memwrite are set, the access is a write (dmem_we=1).
- aligned = (ex_aluresult[1:0] == 0).
- IDLE, ex_valid & !memop:
  - stall = 0.
  - Next edge: wb_valid=1, wb_regwrite=ex_regwrite, wb_rd=ex_rd, wb_data=ex_aluresult.
  - Latency is 1 cycle.
- IDLE, ex_valid & memop & !aligned:
  - No request; stall = 0.
  - Next edge: mem_err=1 for one cycle, wb_valid=0, wb_regwrite=0 (bubble).
- IDLE, ex_valid & memop & aligned:
  - stall = 1.
  - Latch address, wdata, we, regwrite, rd and memread into internal registers.
  - Go to WAIT; counter cleared.
- WAIT (Moore outputs):
  - dmem_req=1, with dmem_we/addr/wdata driven from the latched registers.
  - stall = !dmem_ack & !(cnt == TIMEOUT-1).
- WAIT & dmem_ack:
  - Next edge: wb_valid=1, wb_regwrite=latched regwrite, wb_rd=latched rd.
  - wb_data = dmem_rdata if the latched access was a load, else the latched address.
  - Return to IDLE.
  - Minimum memory-op latency: 2 cycles (1 IDLE stall cycle plus the ack cycle).
- WAIT & !dmem_ack & cnt == TIMEOUT-1:
  - Next edge: mem_err=1, wb_valid=0, wb_regwrite=0, dmem_req=0.
  - Return to IDLE; the instruction is dropped.
- WAIT & !dmem_ack otherwise: cnt++.
- ex_valid=0 in IDLE: stall = 0; next edge wb_valid=0, wb_regwrite=0.
- On any bubble, wb_rd and wb_data hold their previous values.
- mem_err is 0 on every cycle that is not a stated pulse.
- dmem_ack while not in WAIT is ignored.
- One request is outstanding at a time. dmem_addr/wdata/we are stable for the whole time dmem_req is high.

Test Plan:
- ALU op: ex_valid=1, regwrite=1, rd=3, aluresult=0x000000A5 -> next cycle wb_valid=1, wb_rd=3, wb_data=0xA5; stall never 1; dmem_req never 1.
- Load at addr 0x100, ack on the 3rd WAIT cycle with rdata=0xDEADBEEF -> dmem_req high exactly 3 cycles; stall high 3 cycles (IDLE entry cycle plus 2 WAIT cycles); following cycle wb_valid=1, wb_data=0xDEADBEEF.
- Store addr 0x200, wdata=0x12345678, ack on the 1st WAIT cycle -> dmem_we=1, dmem_wdata=0x12345678; stall high 1 cycle; then wb_valid=1, wb_regwrite=0.
- Load at 0x300, ack never arrives, TIMEOUT=15 -> dmem_req high 15 cycles; stall high 15 cycles (IDLE entry cycle plus the first 14 WAIT cycles, low on the 15th); then mem_err=1 for 1 cycle, dmem_req=0, wb_valid=0.
- Load at 0x102 (misaligned) -> dmem_req stays 0, stall stays 0; next cycle mem_err=1, wb_valid=0, wb_regwrite=0.
- rst_n=0 on the 2nd WAIT cycle, then dmem_ack=1 after release -> next edge: dmem_req=0, stall=0, wb_*=0, mem_err=0; the late ack produces no writeback.
